gold_seq_scheduler: RTL and testbench

Controller that sequences the Gold-code generator user module. It drives the generator's load and output-select controls. It also tracks chip position within each code period (2^LFSR_LEN-1 chips) and marks epoch boundaries. Output-select changes, from a requester or an automatic rotation, are committed only at epoch boundaries so the selected code never switches mid-period.

---
 rtl/gold_seq_scheduler.sv | 168 ++++++++++++++++
 tb/tb_gold_seq_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gold_seq_scheduler.sv
// Sequencer for the Gold-code generator: load pulse, chip/epoch tracking,
// and output-select changes committed only on code-period boundaries.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | generator held in load, select changes applied immediately
// ST_LOAD | load_gold_n held low for LOAD_CYCLES cycles
// ST_RUN  | generator free-running, chip_idx counts through the period
module gold_seq_scheduler #(
    parameter int LFSR_LEN       = 5,
    parameter int LOAD_CYCLES    = 1,
    parameter int EPOCHS_PER_SEL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                auto_rot,
    input  logic                sel_req,
    input  logic                sel_val,
    output logic                sel_ack,
    output logic                load_gold_n,
    output logic                mux_sel,
    output logic [LFSR_LEN-1:0] chip_idx,
    output logic                epoch_start,
    output logic [7:0]          epoch_cnt,
    output logic                busy
);

    localparam int LD_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int ROT_W = (EPOCHS_PER_SEL > 1) ? $clog2(EPOCHS_PER_SEL) : 1;
    localparam logic [LFSR_LEN-1:0] CHIP_LAST = LFSR_LEN'((1 << LFSR_LEN) - 2);
    localparam logic [LD_W-1:0]     LD_INIT   = LD_W'(LOAD_CYCLES - 1);
    localparam logic [ROT_W-1:0]    ROT_INIT  = ROT_W'(EPOCHS_PER_SEL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t              state, state_nx;
    logic [LD_W-1:0]     load_cnt, load_cnt_nx;
    logic [ROT_W-1:0]    rot_cnt, rot_cnt_nx;
    logic                stop_pend, stop_pend_nx;
    logic                sel_ack_nx, load_gold_n_nx, mux_sel_nx, epoch_start_nx, busy_nx;
    logic [LFSR_LEN-1:0] chip_idx_nx;
    logic [7:0]          epoch_cnt_nx;
    logic                boundary, sel_pend, stop_any;

    always_comb begin
        // sel_req is still high during its own ack cycle; don't commit it twice
        sel_pend = sel_req & ~sel_ack;
        stop_any = stop_pend | stop;
        boundary = (state == ST_RUN) && (chip_idx == CHIP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: if (load_cnt == '0) state_nx = ST_RUN;
            ST_RUN:  if (boundary && stop_any) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        load_cnt_nx    = load_cnt;
        rot_cnt_nx     = rot_cnt;
        stop_pend_nx   = stop_pend;
        chip_idx_nx    = chip_idx;
        epoch_cnt_nx   = epoch_cnt;
        mux_sel_nx     = mux_sel;
        sel_ack_nx     = 1'b0;
        epoch_start_nx = 1'b0;
        load_gold_n_nx = (state_nx == ST_RUN);
        busy_nx        = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                stop_pend_nx = 1'b0;
                chip_idx_nx  = '0;
                if (sel_pend) begin
                    mux_sel_nx = sel_val;
                    sel_ack_nx = 1'b1;
                    rot_cnt_nx = ROT_INIT;
                end
                if (start) begin
                    load_cnt_nx  = LD_INIT;
                    epoch_cnt_nx = '0;
                    rot_cnt_nx   = ROT_INIT;
                end
            end
            ST_LOAD: begin
                if (stop) stop_pend_nx = 1'b1;
                if (sel_pend) begin
                    mux_sel_nx = sel_val;
                    sel_ack_nx = 1'b1;
                    rot_cnt_nx = ROT_INIT;
                end
                if (load_cnt == '0) begin
                    chip_idx_nx    = '0;
                    epoch_start_nx = 1'b1;
                end else begin
                    load_cnt_nx = load_cnt - LD_W'(1);
                end
            end
            ST_RUN: begin
                if (stop) stop_pend_nx = 1'b1;
                chip_idx_nx = chip_idx + LFSR_LEN'(1);
                if (boundary) begin
                    chip_idx_nx  = '0;
                    epoch_cnt_nx = epoch_cnt + 8'd1;
                    if (sel_pend) begin
                        mux_sel_nx = sel_val;
                        sel_ack_nx = 1'b1;
                        rot_cnt_nx = ROT_INIT;
                    end else if (rot_cnt == '0) begin
                        // terminal count saturates until auto_rot allows a toggle
                        if (auto_rot) begin
                            mux_sel_nx = ~mux_sel;
                            rot_cnt_nx = ROT_INIT;
                        end
                    end else begin
                        rot_cnt_nx = rot_cnt - ROT_W'(1);
                    end
                    if (stop_any) begin
                        stop_pend_nx = 1'b0;
                    end else begin
                        epoch_start_nx = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt    <= '0;
            rot_cnt     <= ROT_INIT;
            stop_pend   <= 1'b0;
            chip_idx    <= '0;
            epoch_cnt   <= '0;
            mux_sel     <= 1'b0;
            sel_ack     <= 1'b0;
            epoch_start <= 1'b0;
            load_gold_n <= 1'b0;
            busy        <= 1'b0;
        end else begin
            load_cnt    <= load_cnt_nx;
            rot_cnt     <= rot_cnt_nx;
            stop_pend   <= stop_pend_nx;
            chip_idx    <= chip_idx_nx;
            epoch_cnt   <= epoch_cnt_nx;
            mux_sel     <= mux_sel_nx;
            sel_ack     <= sel_ack_nx;
            epoch_start <= epoch_start_nx;
            load_gold_n <= load_gold_n_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_gold_seq_scheduler.sv
// Directed bench for gold_seq_scheduler with LFSR_LEN=5 (period 31),
// LOAD_CYCLES=1, EPOCHS_PER_SEL=4.
module tb_gold_seq_scheduler;

    localparam int P = 31;

    logic       clk = 1'b0;
    logic       rst, start, stop, auto_rot, sel_req, sel_val;
    logic       sel_ack, load_gold_n, mux_sel, epoch_start, busy;
    logic [4:0] chip_idx;
    logic [7:0] epoch_cnt;

    int total = 0;
    int bad   = 0;

    gold_seq_scheduler #(
        .LFSR_LEN       (5),
        .LOAD_CYCLES    (1),
        .EPOCHS_PER_SEL (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .auto_rot    (auto_rot),
        .sel_req     (sel_req),
        .sel_val     (sel_val),
        .sel_ack     (sel_ack),
        .load_gold_n (load_gold_n),
        .mux_sel     (mux_sel),
        .chip_idx    (chip_idx),
        .epoch_start (epoch_start),
        .epoch_cnt   (epoch_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".load_gold_n"}, load_gold_n, 0);
        chk({tag, ".busy"},        busy, 0);
        chk({tag, ".mux_sel"},     mux_sel, 0);
        chk({tag, ".chip_idx"},    chip_idx, 0);
        chk({tag, ".epoch_start"}, epoch_start, 0);
        chk({tag, ".sel_ack"},     sel_ack, 0);
        chk({tag, ".epoch_cnt"},   epoch_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; auto_rot = 1'b0;
        sel_req = 1'b0; sel_val = 1'b0;
        ticks(2);
        rst = 1'b0;
        chk_reset_vals("rst0");

        // basic sequencing and first wrap
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1.c1.load_gold_n", load_gold_n, 0);
        chk("t1.c1.busy", busy, 1);
        tick();
        chk("t1.c2.load_gold_n", load_gold_n, 1);
        chk("t1.c2.chip_idx", chip_idx, 0);
        chk("t1.c2.epoch_start", epoch_start, 1);
        ticks(30);
        chk("t1.c32.chip_idx", chip_idx, 30);
        chk("t1.c32.epoch_start", epoch_start, 0);
        tick();
        chk("t1.c33.chip_idx", chip_idx, 0);
        chk("t1.c33.epoch_start", epoch_start, 1);
        chk("t1.c33.epoch_cnt", epoch_cnt, 1);

        // select request in RUN waits for the boundary
        ticks(10);
        chk("t2.chip10", chip_idx, 10);
        sel_req = 1'b1; sel_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2.wait.mux_sel", mux_sel, 0);
            chk("t2.wait.sel_ack", sel_ack, 0);
        end
        tick();
        chk("t2.wrap.chip_idx", chip_idx, 0);
        chk("t2.wrap.mux_sel", mux_sel, 1);
        chk("t2.wrap.sel_ack", sel_ack, 1);
        chk("t2.wrap.epoch_cnt", epoch_cnt, 2);
        sel_req = 1'b0;
        tick();
        chk("t2.after.sel_ack", sel_ack, 0);
        chk("t2.after.mux_sel", mux_sel, 1);

        // auto rotation every 4 epochs
        do_reset();
        chk_reset_vals("t3.rst");
        auto_rot = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k <= 9 * P; k++) begin
            chk("t3.chip_idx", chip_idx, k % P);
            chk("t3.mux_sel", mux_sel, ((k / P) / 4) % 2);
            chk("t3.epoch_start", epoch_start, (k % P) == 0);
            if ((k % P) == 0) chk("t3.epoch_cnt", epoch_cnt, k / P);
            tick();
        end
        auto_rot = 1'b0;

        // stop with a pending select request
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(6);
        chk("t4.chip5", chip_idx, 5);
        stop = 1'b1; sel_req = 1'b1; sel_val = 1'b1;
        tick();
        stop = 1'b0;
        ticks(24);
        chk("t4.c30.chip_idx", chip_idx, 30);
        chk("t4.c30.busy", busy, 1);
        chk("t4.c30.mux_sel", mux_sel, 0);
        tick();
        chk("t4.wrap.sel_ack", sel_ack, 1);
        chk("t4.wrap.mux_sel", mux_sel, 1);
        chk("t4.wrap.epoch_start", epoch_start, 0);
        chk("t4.wrap.epoch_cnt", epoch_cnt, 1);
        sel_req = 1'b0;
        tick();
        chk("t4.idle.load_gold_n", load_gold_n, 0);
        chk("t4.idle.busy", busy, 0);
        chk("t4.idle.chip_idx", chip_idx, 0);
        chk("t4.idle.epoch_start", epoch_start, 0);
        chk("t4.idle.sel_ack", sel_ack, 0);
        ticks(3);
        chk("t4.stay.busy", busy, 0);

        // stop during LOAD: exactly one epoch runs
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4b.run.busy", busy, 1);
        ticks(30);
        chk("t4b.c30.chip_idx", chip_idx, 30);
        chk("t4b.c30.busy", busy, 1);
        tick();
        chk("t4b.end.busy", busy, 0);
        chk("t4b.end.epoch_start", epoch_start, 0);

        // reset mid-RUN, mux_sel is 1 going in
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ticks(P + 17);
        chk("t5.chip17", chip_idx, 17);
        chk("t5.epoch_cnt", epoch_cnt, 1);
        chk("t5.mux_pre", mux_sel, 1);
        do_reset();
        chk_reset_vals("t5.rst");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.c1.epoch_start", epoch_start, 0);
        tick();
        chk("t5.c2.epoch_start", epoch_start, 1);
        chk("t5.c2.chip_idx", chip_idx, 0);

        // select in IDLE, then start together with rst
        do_reset();
        sel_req = 1'b1; sel_val = 1'b1;
        tick();
        chk("t6.idle.mux_sel", mux_sel, 1);
        chk("t6.idle.sel_ack", sel_ack, 1);
        tick();
        chk("t6.hold.sel_ack", sel_ack, 0);
        sel_req = 1'b0;
        tick();
        chk("t6.drop.sel_ack", sel_ack, 0);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_reset_vals("t6.rststart");
        tick();
        chk("t6.stay.busy", busy, 0);
        chk("t6.stay.load_gold_n", load_gold_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
